// File: rtl/hilo_muldiv_if.sv
// ---------------------------------------------------------------------------
// hilo_muldiv_if
//   Request/response bundle between the decode stage (master) and the
//   iterative multiply/divide unit with HI/LO registers (slave).
//
//   in_valid / in_ready : op handshake, accepted when both are high at clk edge
//   in_op               : operation code (MULT, MULTU, DIV, DIVU, MTHI, MTLO,
//                         MADD, MADDU)
//   s_data / t_data     : rs / rt operands
//   flush               : exception flush, aborts any in-flight op
//   busy                : multi-cycle op in flight
//   done                : one-cycle pulse, HI/LO hold a new result
//   hi / lo             : architectural HI / LO registers
// ---------------------------------------------------------------------------
interface hilo_muldiv_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            in_op;
    logic [DATA_WIDTH-1:0] s_data;
    logic [DATA_WIDTH-1:0] t_data;
    logic                  flush;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;

    modport master (
        output in_valid, in_op, s_data, t_data, flush,
        input  in_ready, busy, done, hi, lo
    );

    modport slave (
        input  in_valid, in_op, s_data, t_data, flush,
        output in_ready, busy, done, hi, lo
    );
endinterface

// File: rtl/hilo_muldiv.sv
// ---------------------------------------------------------------------------
// hilo_muldiv
//   Iterative multiply/divide unit owning the HI/LO registers. MULT/DIV run
//   one bit per cycle (shift-add / restoring division) on operand magnitudes;
//   a final FIX cycle applies the sign and writes HI/LO. MTHI/MTLO complete
//   in the accept cycle.
//
//   Ports:
//     clk   : rising-edge clock
//     rst_n : synchronous active-low reset
//     bus   : hilo_muldiv_if.slave (handshake, operands, flush, busy, done,
//             hi, lo)
//
//   Optional feature macro: HILO_MADD_EN
//     defined   : ops 110/111 (MADD/MADDU) accumulate s*t into {hi,lo}
//     undefined : ops 110/111 are accepted as single-cycle no-ops
// ---------------------------------------------------------------------------
module hilo_muldiv #(
    parameter int DATA_WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    hilo_muldiv_if.slave    bus
);
    localparam int N  = DATA_WIDTH;
    localparam int CW = $clog2(N);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic           busy_q;
    logic           done_q;
    logic [N-1:0]   hi_q;
    logic [N-1:0]   lo_q;
    // a_q: multiplicand or divisor magnitude.
    // p_hi_q/p_lo_q: product accumulator during MUL; remainder/quotient during DIV.
    logic [N-1:0]   a_q;
    logic [N-1:0]   p_hi_q;
    logic [N-1:0]   p_lo_q;
    logic [N-1:0]   s_q;        // raw dividend, needed for the divide-by-zero result
    logic           is_div_q;
    logic           neg_q;      // product / quotient must be negated in FIX
    logic           rem_neg_q;  // remainder takes the dividend sign
    logic           div0_q;
`ifdef HILO_MADD_EN
    logic           mac_q;      // accumulate into {hi,lo} in FIX
`endif

    // Decode and operand conditioning
    logic           accept;
    logic           start_mul;
    logic           start_div;
    logic           s_neg;
    logic           t_neg;
    logic [N-1:0]   s_mag;
    logic [N-1:0]   t_mag;

    always_comb begin
        accept    = bus.in_valid & bus.in_ready;
        start_mul = accept & ((bus.in_op == OP_MULT) | (bus.in_op == OP_MULTU)
`ifdef HILO_MADD_EN
                              | (bus.in_op[2:1] == 2'b11)
`endif
                              );
        start_div = accept & ((bus.in_op == OP_DIV) | (bus.in_op == OP_DIVU));
        // Signed variants all have in_op[0] == 0.
        s_neg     = ~bus.in_op[0] & bus.s_data[N-1];
        t_neg     = ~bus.in_op[0] & bus.t_data[N-1];
        s_mag     = s_neg ? -bus.s_data : bus.s_data;
        t_mag     = t_neg ? -bus.t_data : bus.t_data;
    end

    // One iteration step of each algorithm
    logic [N:0]     mul_sum;
    logic [N:0]     div_shift;
    logic [N:0]     div_trial;

    always_comb begin
        mul_sum   = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, a_q} : '0);
        // Bring the next dividend bit into the partial remainder, then trial-subtract.
        div_shift = {p_hi_q, p_lo_q[N-1]};
        div_trial = div_shift - {1'b0, a_q};
    end

    // Result formation for the FIX cycle
    logic [2*N-1:0] prod_raw;
    logic [2*N-1:0] mul_result;
    logic [N-1:0]   quo;
    logic [N-1:0]   rem;

    always_comb begin
        prod_raw   = {p_hi_q, p_lo_q};
        mul_result = neg_q ? -prod_raw : prod_raw;
`ifdef HILO_MADD_EN
        if (mac_q) begin
            mul_result = {hi_q, lo_q} + (neg_q ? -prod_raw : prod_raw);
        end
`endif
        quo        = neg_q ? -p_lo_q : p_lo_q;
        rem        = rem_neg_q ? -p_hi_q : p_hi_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            a_q       <= '0;
            p_hi_q    <= '0;
            p_lo_q    <= '0;
            s_q       <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
`ifdef HILO_MADD_EN
            mac_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (bus.flush) begin
                // Abort whatever is in flight, including a pending FIX write.
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start_mul) begin
                            a_q      <= s_mag;
                            p_hi_q   <= '0;
                            p_lo_q   <= t_mag;
                            neg_q    <= s_neg ^ t_neg;
                            is_div_q <= 1'b0;
`ifdef HILO_MADD_EN
                            mac_q    <= bus.in_op[2];
`endif
                            cnt_q    <= CW'(N - 1);
                            busy_q   <= 1'b1;
                            state_q  <= S_MUL;
                        end else if (start_div) begin
                            a_q       <= t_mag;
                            p_hi_q    <= '0;
                            p_lo_q    <= s_mag;
                            s_q       <= bus.s_data;
                            neg_q     <= s_neg ^ t_neg;
                            rem_neg_q <= s_neg;
                            div0_q    <= (bus.t_data == '0);
                            is_div_q  <= 1'b1;
                            cnt_q     <= CW'(N - 1);
                            busy_q    <= 1'b1;
                            state_q   <= S_DIV;
                        end else if (accept && bus.in_op == OP_MTHI) begin
                            hi_q <= bus.s_data;
                        end else if (accept && bus.in_op == OP_MTLO) begin
                            lo_q <= bus.s_data;
                        end
                        // Any other accepted op is a single-cycle no-op.
                    end
                    S_MUL: begin
                        p_hi_q <= mul_sum[N:1];
                        p_lo_q <= {mul_sum[0], p_lo_q[N-1:1]};
                        cnt_q  <= cnt_q - 1'b1;
                        if (cnt_q == '0) begin
                            state_q <= S_FIX;
                        end
                    end
                    S_DIV: begin
                        if (!div_trial[N]) begin
                            p_hi_q <= div_trial[N-1:0];
                            p_lo_q <= {p_lo_q[N-2:0], 1'b1};
                        end else begin
                            p_hi_q <= div_shift[N-1:0];
                            p_lo_q <= {p_lo_q[N-2:0], 1'b0};
                        end
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == '0) begin
                            state_q <= S_FIX;
                        end
                    end
                    S_FIX: begin
                        if (is_div_q) begin
                            if (div0_q) begin
                                lo_q <= '1;
                                hi_q <= s_q;
                            end else begin
                                lo_q <= quo;
                                hi_q <= rem;
                            end
                        end else begin
                            {hi_q, lo_q} <= mul_result;
                        end
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.in_ready = ~busy_q & ~bus.flush;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
`timescale 1ns/1ps
module tb_hilo_muldiv;
    localparam int W = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MADD  = 3'b110;
    localparam logic [2:0] OP_MADDU = 3'b111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hilo_muldiv_if #(.DATA_WIDTH(W)) bus ();

    hilo_muldiv #(.DATA_WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_result(input string name, input logic [31:0] eh, input logic [31:0] el);
        exp_t e;
        e.hi   = eh;
        e.lo   = el;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every done pulse consumes one expected result.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 hi=%h lo=%h expected no done", bus.hi, bus.lo);
                end else begin
                    e = exp_q.pop_front();
                    check32({e.name, "_hi"}, bus.hi, e.hi);
                    check32({e.name, "_lo"}, bus.lo, e.lo);
                    $display("txn %s: hi=%h lo=%h (expected %h %h)", e.name, bus.hi, bus.lo, e.hi, e.lo);
                end
            end
        end
    end

    // Present an op and hold it until accepted; returns just after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] s, input logic [31:0] t);
        int n;
        n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.s_data   = s;
        bus.t_data   = t;
        while (bus.in_ready !== 1'b1) begin
            n++;
            if (n > 100) begin
                checks++;
                errors++;
                $display("FAIL issue_timeout: in_ready=%b expected 1", bus.in_ready);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        // Scramble operands: the unit must have captured them at acceptance.
        bus.s_data   = 32'hA5A5_5A5A;
        bus.t_data   = 32'h5A5A_A5A5;
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] s,
                          input logic [31:0] t, input logic [31:0] eh, input logic [31:0] el);
        int n;
        n = 0;
        expect_result(name, eh, el);
        issue(op, s, t);
        @(negedge clk);
        while (bus.busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check32({name, "_busy_cycles"}, n, W + 1);
        check32({name, "_done_pulse"}, {31'b0, bus.done}, 32'd1);
    endtask

    initial begin
        int n;
        bus.in_valid = 1'b0;
        bus.in_op    = 3'b000;
        bus.s_data   = '0;
        bus.t_data   = '0;
        bus.flush    = 1'b0;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check32("reset_hi", bus.hi, 32'h0);
        check32("reset_lo", bus.lo, 32'h0);
        check32("reset_busy", {31'b0, bus.busy}, 32'd0);
        check32("reset_done", {31'b0, bus.done}, 32'd0);
        check32("reset_in_ready", {31'b0, bus.in_ready}, 32'd1);
        rst_n = 1'b1;

        // Multiplies
        run_op("mult_m3x5",     OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("mult_min_sq",   OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_op("multu_shift",   OP_MULTU, 32'h1234_5678, 32'h0000_1000, 32'h0000_0123, 32'h4567_8000);

        // Divides
        run_op("divu_100_7",    OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14);
        run_op("div_m7_2",      OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_7_m2",      OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("div_123_0",     OP_DIV,   32'h0000_007B, 32'h0,         32'h0000_007B, 32'hFFFF_FFFF);
        run_op("div_m7_0",      OP_DIV,   32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_op("divu_max_0",    OP_DIVU,  32'hFFFF_FFFF, 32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div_min_m1",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op("divu_min_max",  OP_DIVU,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000);

        // MTHI / MTLO: single cycle, no busy, no done
        issue(OP_MTHI, 32'hDEAD_BEEF, 32'h0);
        check32("mthi_hi", bus.hi, 32'hDEAD_BEEF);
        check32("mthi_busy", {31'b0, bus.busy}, 32'd0);
        check32("mthi_done", {31'b0, bus.done}, 32'd0);
        issue(OP_MTLO, 32'h1234_5678, 32'h0);
        check32("mtlo_lo", bus.lo, 32'h1234_5678);
        check32("mtlo_hi_kept", bus.hi, 32'hDEAD_BEEF);

        // Back-to-back: MULTU held while MULT runs, accepted in the done cycle
        expect_result("mult_7xm6", 32'hFFFF_FFFF, 32'hFFFF_FFD6);
        issue(OP_MULT, 32'd7, 32'hFFFF_FFFA);
        expect_result("b2b_multu", 32'hFFFF_FFFE, 32'h0000_0001);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = OP_MULTU;
        bus.s_data   = 32'hFFFF_FFFF;
        bus.t_data   = 32'hFFFF_FFFF;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check32("b2b_wait_cycles", n, W + 1);
        check32("b2b_ready_in_done_cycle", {31'b0, bus.done}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check32("b2b_busy_after_accept", {31'b0, bus.busy}, 32'd1);
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check32("b2b_busy_done", {31'b0, bus.busy}, 32'd0);

        // Flush mid-operation
        issue(OP_MTHI, 32'd1, 32'h0);
        issue(OP_MTLO, 32'd2, 32'h0);
        issue(OP_MULTU, 32'd3, 32'd4);
        repeat (10) @(negedge clk);
        bus.flush = 1'b1;
        check32("flush_blocks_ready", {31'b0, bus.in_ready}, 32'd0);
        @(negedge clk);
        bus.flush = 1'b0;
        check32("flush_busy", {31'b0, bus.busy}, 32'd0);
        check32("flush_hi", bus.hi, 32'd1);
        check32("flush_lo", bus.lo, 32'd2);
        check32("flush_done", {31'b0, bus.done}, 32'd0);
        repeat (40) @(negedge clk);
        check32("flush_no_late_write_lo", bus.lo, 32'd2);

        // Flush wins over a simultaneous request
        bus.in_valid = 1'b1;
        bus.in_op    = OP_MTHI;
        bus.s_data   = 32'hFFFF_0000;
        bus.flush    = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        check32("flush_beats_valid_hi", bus.hi, 32'd1);

        // Flush during the FIX cycle suppresses the write
        issue(OP_MULTU, 32'd3, 32'd4);
        repeat (W + 1) @(negedge clk);
        check32("fix_cycle_busy", {31'b0, bus.busy}, 32'd1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check32("flush_fix_hi", bus.hi, 32'd1);
        check32("flush_fix_lo", bus.lo, 32'd2);
        check32("flush_fix_busy", {31'b0, bus.busy}, 32'd0);
        repeat (3) @(negedge clk);

        // Reset mid-operation
        issue(OP_MULTU, 32'd3, 32'd4);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check32("rst_mid_hi", bus.hi, 32'd0);
        check32("rst_mid_lo", bus.lo, 32'd0);
        check32("rst_mid_busy", {31'b0, bus.busy}, 32'd0);
        repeat (40) @(negedge clk);

        // MADD / MADDU
        issue(OP_MTHI, 32'h0, 32'h0);
        issue(OP_MTLO, 32'hFFFF_FFFF, 32'h0);
`ifdef HILO_MADD_EN
        run_op("maddu_carry", OP_MADDU, 32'd1, 32'd1, 32'h0000_0001, 32'h0000_0000);
        run_op("madd_neg",    OP_MADD,  32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 32'hFFFF_FFFF);
`else
        issue(OP_MADDU, 32'd1, 32'd1);
        check32("maddu_noop_busy", {31'b0, bus.busy}, 32'd0);
        check32("maddu_noop_hi", bus.hi, 32'h0);
        check32("maddu_noop_lo", bus.lo, 32'hFFFF_FFFF);
        @(negedge clk);
        check32("maddu_noop_done", {31'b0, bus.done}, 32'd0);
        check32("maddu_noop_ready", {31'b0, bus.in_ready}, 32'd1);
`endif

        repeat (5) @(negedge clk);
        check32("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
